mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one downstream memory port between the fetch stage's instruction requester (imem) and the load/store data requester (dmem).
- Grants one transaction at a time. Round-robin fairness applies when both requesters are pending.
- The request is latched into internal registers at grant. The memory response is routed back in the same cycle it arrives.
- An imem flush input discards a stale fetch response that is still in flight after a redirect.

Parameters:
- ADDRW, 32, address width of all ports.
- DATAW, 32, data width of all ports; DATAW/8 byte strobes.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- imem_valid_i  in  1  fetch request; held high until imem_resp_o.
- imem_addr_i  in  ADDRW  fetch address; word aligned.
- imem_flush_i  in  1  discard any outstanding fetch response (redirect).
- imem_rdata_o  out  DATAW  fetch read data; valid only when imem_resp_o=1.
- imem_resp_o  out  1  one-cycle fetch completion pulse.
- dmem_valid_i  in  1  data request; held with stable fields until dmem_resp_o.
- dmem_addr_i  in  ADDRW  data address.
- dmem_we_i  in  1  1=store, 0=load.
- dmem_wdata_i  in  DATAW  store data.
- dmem_wstrb_i  in  DATAW/8  store byte strobes; ignored for loads.
- dmem_rdata_o  out  DATAW  load data; valid only when dmem_resp_o=1.
- dmem_resp_o  out  1  one-cycle data completion pulse.
- mem_valid_o  out  1  downstream request; held until mem_resp_i.
- mem_addr_o  out  ADDRW  latched address.
- mem_we_o  out  1  latched write enable; 0 for imem.
- mem_wdata_o  out  DATAW  latched store data; 0 for imem.
- mem_wstrb_o  out  DATAW/8  latched strobes; 0 for imem and loads.
- mem_rdata_i  in  DATAW  downstream read data, valid with mem_resp_i.
- mem_resp_i  in  1  downstream completion pulse; at most one per accepted request.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Internal state also includes a last_grant bit (0=imem, 1=dmem) and a drop_i flag.
- Reset (rst_ni=0 at a clock edge): state=IDLE, last_grant=1 so imem wins the first tie, drop_i=0, and all mem_* address/data registers = 0.
- Output values during reset and in IDLE: mem_valid_o=0, imem_resp_o=0, dmem_resp_o=0.
- Reset asserted mid-transaction: the transaction is abandoned and no resp pulse is generated. A late mem_resp_i arriving in IDLE is ignored.
- Grant decision. A grant is evaluated in IDLE, and also in BUSY_* during the cycle that mem_resp_i=1 (back-to-back grant).
  - Only imem pending -> grant I. Only dmem pending -> grant D.
  - Both pending -> grant the requester that is not last_grant.
  - On a grant: latch the winner's fields into the mem_* registers, set last_grant, and go to BUSY_I or BUSY_D.
  - No requester pending -> go to IDLE.
- In the response cycle of a transaction, the requester that just completed is excluded from the grant decision. Its valid may still be high that cycle. It becomes eligible again the next cycle.
- mem_valid_o = (state != IDLE), driven from registers. Latency from the request sampled in IDLE to mem_valid_o is 1 cycle. Back-to-back grants keep mem_valid_o high with no gap.
- Requests arriving while BUSY wait; requester valid is never acknowledged early.
- Response routing is combinational in the cycle mem_resp_i=1:
  - BUSY_D: dmem_resp_o=1, dmem_rdata_o=mem_rdata_i.
  - BUSY_I: imem_resp_o = !drop_i && !imem_flush_i; imem_rdata_o=mem_rdata_i.
  - rdata outputs pass mem_rdata_i through at all times. Consumers qualify them with resp.
- Flush rules:
  - imem_flush_i=1 in BUSY_I without mem_resp_i -> drop_i<=1.
  - drop_i is cleared when BUSY_I completes. The dropped transaction still completes downstream and is never aborted.
  - Flush in IDLE or BUSY_D has no effect.
  - Flush in the same cycle as the BUSY_I response suppresses that response.
- Only one transaction is outstanding at a time. mem_resp_i in IDLE is ignored, which is a protocol error at the bench level and must be assertion-checked.
- Widths: all fields pass through unmodified. No address arithmetic.

Test Plan:
- Single fetch: imem_valid_i=1 with addr 0x1000 in IDLE -> next cycle mem_valid_o=1, mem_addr_o=0x1000, mem_we_o=0. mem_resp_i with rdata 0x00000013 two cycles later -> imem_resp_o=1 that same cycle with imem_rdata_o=0x00000013, dmem_resp_o=0.
- Contention after reset: both valid in the first cycle (imem 0x1000; dmem load 0x2000) -> imem is granted first. On its resp, mem_addr_o=0x2000 the next cycle with mem_valid_o continuously high. Both requests held continuously -> grants alternate I, D, I, D.
- Store: dmem_we_i=1, addr 0x2004, wdata 0xDEADBEEF, wstrb 0b0011 -> mem_* show exactly those values. dmem_resp_o pulses once with mem_resp_i.
- Flush: grant I at 0x1000, pulse imem_flush_i one cycle before mem_resp_i -> imem_resp_o stays 0, the next imem request (0x2000) is granted afterwards, and its resp is delivered normally. Repeat with the flush coincident with mem_resp_i -> response suppressed.
- Mid-transaction reset: rst_ni=0 in BUSY_D -> next cycle mem_valid_o=0, state IDLE. A subsequent stray mem_resp_i -> no resp pulses.
- Long stall: mem_resp_i delayed 20 cycles -> mem_* fields stable throughout, even while dmem_addr_i changes and imem_valid_i toggles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory port between fetch (imem) and load/store (dmem)
module mem_arbiter #(
    parameter int ADDRW = 32,
    parameter int DATAW = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               imem_valid_i,
    input  logic [ADDRW-1:0]   imem_addr_i,
    input  logic               imem_flush_i,
    output logic [DATAW-1:0]   imem_rdata_o,
    output logic               imem_resp_o,
    input  logic               dmem_valid_i,
    input  logic [ADDRW-1:0]   dmem_addr_i,
    input  logic               dmem_we_i,
    input  logic [DATAW-1:0]   dmem_wdata_i,
    input  logic [DATAW/8-1:0] dmem_wstrb_i,
    output logic [DATAW-1:0]   dmem_rdata_o,
    output logic               dmem_resp_o,
    output logic               mem_valid_o,
    output logic [ADDRW-1:0]   mem_addr_o,
    output logic               mem_we_o,
    output logic [DATAW-1:0]   mem_wdata_o,
    output logic [DATAW/8-1:0] mem_wstrb_o,
    input  logic [DATAW-1:0]   mem_rdata_i,
    input  logic               mem_resp_i
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_last;
    logic                 r_drop;
    logic [ADDRW-1:0]     r_addr;
    logic                 r_we;
    logic [DATAW-1:0]     r_wdata;
    logic [DATAW/8-1:0]   r_wstrb;
    logic                 w_eval;
    logic                 w_ip;
    logic                 w_dp;
    logic                 w_gi;
    logic                 w_gd;

    // Grant decision (idle or response cycle, completing requester excluded) and response routing
    always_comb begin
        w_eval      = (r_state == IDLE) || mem_resp_i;
        w_ip        = imem_valid_i && (r_state != BUSY_I);
        w_dp        = dmem_valid_i && (r_state != BUSY_D);
        w_gi        = w_eval && w_ip && (!w_dp || r_last);
        w_gd        = w_eval && w_dp && !w_gi;
        w_next      = w_gi ? BUSY_I : w_gd ? BUSY_D : w_eval ? IDLE : r_state;
        imem_resp_o = rst_ni && (r_state == BUSY_I) && mem_resp_i && !r_drop && !imem_flush_i;
        dmem_resp_o = rst_ni && (r_state == BUSY_D) && mem_resp_i;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Latch the winner's request, track fairness and stale-fetch drop
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last  <= 1'b1;
            r_drop  <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            if (w_gi) begin
                r_addr  <= imem_addr_i;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_wstrb <= '0;
                r_last  <= 1'b0;
            end else if (w_gd) begin
                r_addr  <= dmem_addr_i;
                r_we    <= dmem_we_i;
                r_wdata <= dmem_wdata_i;
                r_wstrb <= dmem_we_i ? dmem_wstrb_i : '0;
                r_last  <= 1'b1;
            end
            if (r_state == BUSY_I) r_drop <= mem_resp_i ? 1'b0 : (r_drop || imem_flush_i);
        end
    end

    assign mem_valid_o  = (r_state != IDLE);
    assign mem_addr_o   = r_addr;
    assign mem_we_o     = r_we;
    assign mem_wdata_o  = r_wdata;
    assign mem_wstrb_o  = r_wstrb;
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    logic        clk_i = 0, rst_ni = 0;
    logic        imem_valid_i = 0, imem_flush_i = 0, imem_resp_o;
    logic [31:0] imem_addr_i = 0, imem_rdata_o;
    logic        dmem_valid_i = 0, dmem_we_i = 0, dmem_resp_o;
    logic [31:0] dmem_addr_i = 0, dmem_wdata_i = 0, dmem_rdata_o;
    logic [3:0]  dmem_wstrb_i = 0;
    logic        mem_valid_o, mem_we_o, mem_resp_i = 0;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
    logic [3:0]  mem_wstrb_o;

    mem_arbiter #(.ADDRW(32), .DATAW(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_valid_i(imem_valid_i), .imem_addr_i(imem_addr_i), .imem_flush_i(imem_flush_i),
        .imem_rdata_o(imem_rdata_o), .imem_resp_o(imem_resp_o),
        .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i), .dmem_we_i(dmem_we_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_wstrb_i(dmem_wstrb_i),
        .dmem_rdata_o(dmem_rdata_o), .dmem_resp_o(dmem_resp_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [31:0] a; logic we; logic [31:0] wd; logic [3:0] ws;} txn_t;
    typedef struct packed {logic d; logic [31:0] v;} rsp_t;

    txn_t tq[$];
    rsp_t rq[$];
    int   total = 0, bad = 0;

    // transaction-level model: owner 0=none 1=imem 2=dmem
    int          m_st = 0, m_nx = 0, wait_cnt = 0;
    bit          m_last_d = 1, m_drop = 0, m_drop_nx = 0, exp_valid = 0, mon_on = 0, stray_ok = 0;
    bit          i_req = 0, i_done = 0, i_served = 0, d_req = 0, d_done = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic        d_we = 0;
    logic [3:0]  d_wstrb = 0;

    // stimulus knobs
    bit          k_rst = 0, k_new_i = 0, k_new_d = 0, k_flush = 0, k_stray = 0, k_d_we = 0;
    int          k_lat = 0;
    logic [31:0] k_i_addr = 0, k_d_addr = 0, k_d_wdata = 0, k_rdata = 0;
    logic [3:0]  k_d_wstrb = 0;

    task automatic step();
        bit resp, ei, ed;
        int who;
        @(posedge clk_i); #1;
        m_st = m_nx;
        m_drop = m_drop_nx;
        exp_valid = (m_st != 0);
        if (i_done) i_req = 0;
        if (d_done) d_req = 0;
        i_done = 0;
        d_done = 0;
        if (!i_req && k_new_i) begin i_req = 1; i_addr = k_i_addr; i_served = 0; end
        if (!d_req && k_new_d) begin
            d_req = 1; d_addr = k_d_addr; d_we = k_d_we; d_wdata = k_d_wdata; d_wstrb = k_d_wstrb;
        end
        if (k_flush && i_req) begin i_addr = k_i_addr; i_served = 0; end
        resp = !k_rst && ((m_st != 0 && wait_cnt == 0) || (m_st == 0 && k_stray));
        stray_ok = k_stray;
        rst_ni = !k_rst;
        imem_valid_i = i_req;
        imem_addr_i = i_addr;
        imem_flush_i = k_flush;
        dmem_valid_i = d_req;
        dmem_addr_i = d_req ? d_addr : $urandom;
        dmem_we_i = d_req ? d_we : 1'($urandom);
        dmem_wdata_i = d_req ? d_wdata : $urandom;
        dmem_wstrb_i = d_req ? d_wstrb : 4'($urandom);
        mem_resp_i = resp;
        mem_rdata_i = k_rdata;
        if (m_st != 0 && !resp && !k_rst) wait_cnt--;
        if (resp && m_st == 2) begin rq.push_back('{1'b1, k_rdata}); d_done = 1; end
        if (resp && m_st == 1 && !m_drop && !k_flush) begin rq.push_back('{1'b0, k_rdata}); i_done = i_served; end
        if (m_st == 1 && k_flush && !resp) m_drop_nx = 1;
        if (resp) m_drop_nx = 0;
        if (k_rst) begin
            m_nx = 0; m_last_d = 1; m_drop_nx = 0;
            i_req = 0; d_req = 0; i_done = 0; d_done = 0;
        end else if (m_st == 0 || resp) begin
            ei = i_req && !(resp && m_st == 1);
            ed = d_req && !(resp && m_st == 2);
            who = (ei && ed) ? (m_last_d ? 1 : 2) : ei ? 1 : ed ? 2 : 0;
            if (who == 1) begin tq.push_back('{i_addr, 1'b0, 32'h0, 4'h0}); i_served = 1; end
            if (who == 2) tq.push_back('{d_addr, d_we, d_wdata, d_we ? d_wstrb : 4'h0});
            if (who != 0) begin m_last_d = (who == 2); wait_cnt = k_lat; end
            m_nx = who;
        end else m_nx = m_st;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset();
        total++;
        if ({mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o, imem_resp_o, dmem_resp_o} !== 72'h0) begin
            bad++;
            $display("FAIL reset_state got valid=%b addr=%h we=%b wdata=%h wstrb=%h iresp=%b dresp=%b want all zero",
                     mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o, imem_resp_o, dmem_resp_o);
        end
    endtask

    // monitor: compares downstream grants and upstream responses with the scoreboard queues
    txn_t held = '0;
    bit   prev_v = 0, prev_r = 0;
    always @(negedge clk_i) if (mon_on) begin
        txn_t got;
        rsp_t e;
        got = '{mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o};
        total++;
        if (mem_valid_o !== exp_valid) begin
            bad++;
            $display("FAIL mem_valid got=%b want=%b t=%0t", mem_valid_o, exp_valid, $time);
        end
        if (mem_valid_o && (!prev_v || prev_r)) begin
            total++;
            if (tq.size() == 0) begin
                bad++;
                $display("FAIL grant got unexpected addr=%h want none t=%0t", mem_addr_o, $time);
            end else begin
                held = tq.pop_front();
                if (got !== held) begin
                    bad++;
                    $display("FAIL grant got=%h want=%h t=%0t", got, held, $time);
                end
            end
        end else if (mem_valid_o) begin
            total++;
            if (got !== held) begin
                bad++;
                $display("FAIL stable got=%h want=%h t=%0t", got, held, $time);
            end
        end
        if (imem_resp_o || dmem_resp_o) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL resp got i=%b d=%b want none t=%0t", imem_resp_o, dmem_resp_o, $time);
            end else begin
                e = rq.pop_front();
                if ({dmem_resp_o, imem_resp_o, e.d ? dmem_rdata_o : imem_rdata_o} !== {e.d, !e.d, e.v}) begin
                    bad++;
                    $display("FAIL resp got d=%b i=%b data=%h want d=%b i=%b data=%h t=%0t", dmem_resp_o, imem_resp_o,
                             e.d ? dmem_rdata_o : imem_rdata_o, e.d, !e.d, e.v, $time);
                end
            end
        end
        prev_v = mem_valid_o;
        prev_r = mem_resp_i;
    end

    // a downstream response with nothing outstanding is a protocol error unless deliberately injected
    always @(posedge clk_i) if (mon_on && rst_ni && !stray_ok)
        assert (!(mem_resp_i && !mem_valid_o)) else $error("FAIL protocol mem_resp_i while idle t=%0t", $time);

    initial begin
        k_rst = 1; run(3); k_rst = 0; mon_on = 1;
        step(); check_reset();
        k_new_i = 1; k_i_addr = 32'h1000; k_lat = 1; k_rdata = 32'h13; step();
        k_new_i = 0; run(5);
        k_rst = 1; step(); k_rst = 0;
        k_new_i = 1; k_new_d = 1; k_i_addr = 32'h1000; k_d_addr = 32'h2000; k_d_we = 0; k_lat = 0; k_rdata = 32'hA5A5_0001;
        run(10);
        k_new_i = 0; k_new_d = 0; run(6);
        k_new_d = 1; k_d_addr = 32'h2004; k_d_we = 1; k_d_wdata = 32'hDEADBEEF; k_d_wstrb = 4'b0011; k_lat = 2;
        k_rdata = 32'h5555_0002; step();
        k_new_d = 0; run(5);
        k_new_i = 1; k_i_addr = 32'h1000; k_lat = 3; k_rdata = 32'h1111_0003; step();
        k_new_i = 0; run(2);
        k_flush = 1; k_i_addr = 32'h2000; k_lat = 1; step();
        k_flush = 0; k_rdata = 32'h2222_0004; run(8);
        k_new_i = 1; k_i_addr = 32'h1000; k_lat = 3; k_rdata = 32'h3333_0005; step();
        k_new_i = 0; run(3);
        k_flush = 1; k_i_addr = 32'h3000; k_lat = 2; step();
        k_flush = 0; k_rdata = 32'h4444_0006; run(6);
        k_new_d = 1; k_d_addr = 32'h4000; k_d_we = 0; k_lat = 5; step();
        k_new_d = 0; run(2);
        k_rst = 1; step(); k_rst = 0;
        step(); check_reset();
        k_stray = 1; step(); k_stray = 0; run(3);
        k_new_i = 1; k_i_addr = 32'h1004; k_lat = 20; k_rdata = 32'h6666_0007; step();
        k_new_i = 0; run(24);
        k_new_d = 1; k_d_addr = 32'h5000; k_d_we = 1; k_d_wdata = 32'hCAFE_F00D; k_d_wstrb = 4'b1100; k_lat = 20; step();
        k_new_d = 0;
        for (int i = 0; i < 24; i++) begin
            k_new_i = (i == 10); k_i_addr = $urandom & ~32'h3; k_flush = (i == 5); k_lat = 1; step();
        end
        k_flush = 0; k_new_i = 0; run(8);
        for (int i = 0; i < 3000; i++) begin
            k_new_i = ($urandom % 3) == 0;
            k_new_d = ($urandom % 3) == 0;
            k_i_addr = $urandom & ~32'h3;
            k_d_addr = $urandom;
            k_d_we = 1'($urandom);
            k_d_wdata = $urandom;
            k_d_wstrb = 4'($urandom);
            k_flush = ($urandom % 12) == 0;
            k_lat = (($urandom % 30) == 0) ? 20 : int'($urandom % 4);
            k_rdata = $urandom;
            k_rst = ($urandom % 250) == 0;
            step();
        end
        k_new_i = 0; k_new_d = 0; k_flush = 0; k_rst = 0; k_lat = 1;
        run(60);
        total++;
        if (tq.size() != 0) begin bad++; $display("FAIL grants_left got=%0d want=0", tq.size()); end
        total++;
        if (rq.size() != 0) begin bad++; $display("FAIL resps_left got=%0d want=0", rq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
